// File: rtl/sym_upsampler_if.sv
// Enable inputs and sample/symbol outputs of the symbol-rate upsampler.
// The master side drives the clock enables and observes the sample stream;
// the slave side is the upsampler itself.
interface sym_upsampler_if #(
    parameter int WIDTH = 18
);
    logic                    sam_clk_en;
    logic                    sym_clk_en;
    logic signed [WIDTH-1:0] sym_out;
    logic signed [WIDTH-1:0] samp_out;
    logic                    samp_valid;
    logic [1:0]              phase;
    logic                    align_err;

    modport master (
        output sam_clk_en,
        output sym_clk_en,
        input  sym_out,
        input  samp_out,
        input  samp_valid,
        input  phase,
        input  align_err
    );

    modport slave (
        input  sam_clk_en,
        input  sym_clk_en,
        output sym_out,
        output samp_out,
        output samp_valid,
        output phase,
        output align_err
    );
endinterface

// File: rtl/sym_upsampler.sv
// 4-ASK PRBS symbol source with 4x upsampling and enable-alignment checking.
// A 15-bit Fibonacci LFSR (x^15+x^14+1) supplies two fresh bits per symbol,
// which are Gray-mapped onto {-3a,-a,+a,+3a}. Each symbol is followed by three
// stuffed samples. Misaligned enables drop the block back to ALIGN until the
// next coincident sam/sym enable.
// Optional feature macro: ZOH_UPSAMPLE_EN -- when defined the stuffed samples
// repeat the current symbol (zero-order hold) instead of being zero.
module sym_upsampler #(
    parameter int                      WIDTH     = 18,
    parameter logic signed [WIDTH-1:0] A_LVL     = 18'sd32768,
    parameter logic [14:0]             LFSR_SEED = 15'h0001
) (
    input  logic               clk,
    input  logic               reset,
    sym_upsampler_if.slave     bus
);

    // Two PRBS bits consumed per 4-ASK symbol.
    localparam int BITS_PER_SYM = 2;

    // Inner and outer constellation levels, computed at the sample width.
    localparam logic signed [WIDTH-1:0] LVL_IN  = A_LVL;
    localparam logic signed [WIDTH-1:0] LVL_OUT = A_LVL + A_LVL + A_LVL;

    typedef enum logic {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [14:0]             r_lfsr;
    logic [14:0]             w_lfsr_next;
    logic signed [WIDTH-1:0] r_sym;
    logic signed [WIDTH-1:0] w_sym_next;
    logic signed [WIDTH-1:0] r_samp;
    logic signed [WIDTH-1:0] w_samp_next;
    logic [1:0]              r_phase;
    logic [1:0]              w_phase_next;
    logic                    r_valid;
    logic                    w_valid_next;
    logic                    r_err;
    logic                    w_err_next;

    logic                    w_sam;
    logic                    w_sym_en;
    logic                    w_start;
    logic                    w_misalign;
    logic signed [WIDTH-1:0] w_sym_new;
    logic signed [WIDTH-1:0] w_stuff;

    // LFSR unrolled over one symbol: step 0 is the current state, the last
    // step is the state after both bits of the new symbol have been shifted in.
    logic [14:0] w_lfsr_step [0:BITS_PER_SYM];

    assign w_lfsr_step[0] = r_lfsr;

    generate
        for (genvar gi = 0; gi < BITS_PER_SYM; gi++) begin : g_lfsr_step
            assign w_lfsr_step[gi+1] = {w_lfsr_step[gi][13:0],
                                        w_lfsr_step[gi][14] ^ w_lfsr_step[gi][13]};
        end
    endgenerate

    assign w_sam    = bus.sam_clk_en;
    assign w_sym_en = bus.sym_clk_en;

    // A symbol starts on a coincident enable, either as the re-entry from
    // ALIGN or as the regular boundary after the fourth sample.
    assign w_start = w_sam && w_sym_en &&
                     ((r_state == ST_ALIGN) || (r_phase == 2'd3));

    // Misalignment is only judged while running: a symbol enable that does
    // not land on phase 3 together with a sample enable, or a fifth sample.
    assign w_misalign = (r_state == ST_RUN) &&
                        ((w_sym_en && ((r_phase != 2'd3) || !w_sam)) ||
                         (w_sam && !w_sym_en && (r_phase == 2'd3)));

    // Gray-coded symbol map on the two freshly generated LFSR bits.
    always_comb begin
        w_sym_new = -LVL_OUT;
        case (w_lfsr_step[BITS_PER_SYM][1:0])
            2'b00:   w_sym_new = -LVL_OUT;
            2'b01:   w_sym_new = -LVL_IN;
            2'b11:   w_sym_new =  LVL_IN;
            default: w_sym_new =  LVL_OUT;
        endcase
    end

`ifdef ZOH_UPSAMPLE_EN
    // Zero-order hold: the in-between samples repeat the current symbol.
    assign w_stuff = r_sym;
`else
    // Zero-stuffing: the downstream filter supplies the 4x gain.
    assign w_stuff = '0;
`endif

    // Next-state and output decode; everything holds unless an enable acts.
    always_comb begin
        w_state_next = r_state;
        w_lfsr_next  = r_lfsr;
        w_sym_next   = r_sym;
        w_samp_next  = r_samp;
        w_phase_next = r_phase;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;

        if (w_start) begin
            w_state_next = ST_RUN;
            w_lfsr_next  = w_lfsr_step[BITS_PER_SYM];
            w_sym_next   = w_sym_new;
            w_samp_next  = w_sym_new;
            w_phase_next = 2'd0;
            w_valid_next = 1'b1;
        end else if (w_misalign) begin
            // The offending symbol enable is consumed here and does not
            // re-align; the next coincident enable does.
            w_state_next = ST_ALIGN;
            w_samp_next  = '0;
            w_phase_next = 2'd0;
            w_err_next   = 1'b1;
        end else if ((r_state == ST_RUN) && w_sam) begin
            w_phase_next = r_phase + 2'd1;
            w_samp_next  = w_stuff;
            w_valid_next = 1'b1;
        end
    end

    // State, PRBS and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ALIGN;
            r_lfsr  <= LFSR_SEED;
            r_sym   <= '0;
            r_samp  <= '0;
            r_phase <= 2'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= w_lfsr_next;
            r_sym   <= w_sym_next;
            r_samp  <= w_samp_next;
            r_phase <= w_phase_next;
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
        end
    end

    assign bus.sym_out    = r_sym;
    assign bus.samp_out   = r_samp;
    assign bus.samp_valid = r_valid;
    assign bus.phase      = r_phase;
    assign bus.align_err  = r_err;

endmodule
